// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the block-memory arbiter:
//     - state_e    : arbiter FSM encoding (IDLE / BUSY / DONE)
//     - PRIO_RR    : round-robin arbitration mode
//     - PRIO_FIXED : fixed-priority arbitration mode (channel 0 highest)
//     - idx_width  : width of a channel index for a given channel count
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic PRIO_RR    = 1'b0;
  localparam logic PRIO_FIXED = 1'b1;

  // A single channel still needs a 1-bit index so vectors never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pick
//   Combinational winner select for the memory arbiter.
//   Ports:
//     req_i    [NUM_CH]  active request per channel
//     rr_ptr_i [IDX_W]   first channel searched in round-robin mode
//     mode_i             PRIO_RR or PRIO_FIXED
//     any_o              at least one channel is requesting
//     winner_o [IDX_W]   index of the winning channel (0 when none)
// -----------------------------------------------------------------------------
module mem_arbiter_pick
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  rr_ptr_i,
  input  logic              mode_i,
  output logic              any_o,
  output logic [IDX_W-1:0]  winner_o
);

  int   idx;
  logic found;

  // Winner search: fixed mode takes the lowest index, round-robin starts at rr_ptr and wraps.
  always_comb begin
    any_o    = |req_i;
    winner_o = '0;
    found    = 1'b0;
    idx      = 0;
    if (mode_i == PRIO_FIXED) begin
      // Walk downwards so the lowest active index is the last one written.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (req_i[i]) begin
          winner_o = IDX_W'(i);
        end else begin
          winner_o = winner_o;
        end
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = (int'(rr_ptr_i) + k) % NUM_CH;
        if (!found && req_i[idx]) begin
          winner_o = IDX_W'(idx);
          found    = 1'b1;
        end else begin
          found    = found;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one block-level memory port between NUM_CH cache-side requesters.
//   One memory transaction is in flight at a time; the same read/write/busywait
//   block protocol is used on the channel side and the memory side.
//   Ports:
//     CLK, RESET       clock (posedge) and synchronous active-high reset
//     ch_read/ch_write per-channel block requests (write wins if both set)
//     ch_address       packed channel addresses, channel i at [i*ADDR_W +: ADDR_W]
//     ch_writedata     packed channel write data, channel i at [i*DATA_W +: DATA_W]
//     ch_readdata      shared read return bus, holds until the next read completes
//     ch_busywait      per-channel stall, released for the single DONE cycle
//     mem_read/mem_write/mem_address/mem_writedata  registered memory request
//     mem_readdata/mem_busywait                     memory response
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_address,
  input  logic [NUM_CH*DATA_W-1:0]   ch_writedata,
  output logic [DATA_W-1:0]          ch_readdata,
  output logic [NUM_CH-1:0]          ch_busywait,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_W-1:0]          mem_address,
  output logic [DATA_W-1:0]          mem_writedata,
  input  logic [DATA_W-1:0]          mem_readdata,
  input  logic                       mem_busywait
);

  localparam int   IDX_W = idx_width(NUM_CH);
  localparam logic MODE  = (PRIO_MODE == 1) ? PRIO_FIXED : PRIO_RR;

  // Registered state and its next-state values
  state_e              state_q,     state_d;
  logic [IDX_W-1:0]    grant_q,     grant_d;
  logic [IDX_W-1:0]    rr_ptr_q,    rr_ptr_d;
  logic                op_wr_q,     op_wr_d;
  logic                first_q,     first_d;
  logic                mem_read_q,  mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rdata_q,     rdata_d;

  logic [NUM_CH-1:0]   req_s;
  logic                any_s;
  logic [IDX_W-1:0]    win_s;

  assign req_s = ch_read | ch_write;

  mem_arbiter_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req_i    (req_s),
    .rr_ptr_i (rr_ptr_q),
    .mode_i   (MODE),
    .any_o    (any_s),
    .winner_o (win_s)
  );

  // Stall every requester except the granted one during its DONE cycle.
  always_comb begin
    ch_busywait = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_busywait[i] = req_s[i] & ~((state_q == DONE) && (grant_q == IDX_W'(i)));
    end
  end

  // FSM next-state: latch the winner in IDLE, wait for memory in BUSY, release in DONE.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    op_wr_d     = op_wr_q;
    first_d     = first_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (any_s) begin
          grant_d     = win_s;
          // Write wins when a channel (illegally) raises both strobes.
          op_wr_d     = ch_write[win_s];
          mem_write_d = ch_write[win_s];
          mem_read_d  = ~ch_write[win_s];
          mem_addr_d  = ch_address[win_s*ADDR_W +: ADDR_W];
          mem_wdata_d = ch_writedata[win_s*DATA_W +: DATA_W];
          first_d     = 1'b1;
          state_d     = BUSY;
        end else begin
          state_d     = IDLE;
        end
      end
      BUSY: begin
        // Memory raises busywait one cycle after the strobe, so the first BUSY
        // cycle's busywait is stale and must not be taken as completion.
        if (first_q) begin
          first_d = 1'b0;
        end else if (!mem_busywait) begin
          if (!op_wr_q) begin
            rdata_d = mem_readdata;
          end else begin
            rdata_d = rdata_q;
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = DONE;
        end else begin
          state_d     = BUSY;
        end
      end
      DONE: begin
        if (grant_q == IDX_W'(NUM_CH - 1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = grant_q + IDX_W'(1);
        end
        state_d = IDLE;
      end
      default: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        first_d     = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      op_wr_q     <= 1'b0;
      first_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      op_wr_q     <= op_wr_d;
      first_q     <= first_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_addr_q;
  assign mem_writedata = mem_wdata_q;
  assign ch_readdata   = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed test of mem_arbiter in three configurations:
//     dut_a : 2 channels, round-robin, with a small latency-programmable memory
//     dut_b : 2 channels, fixed priority, memory that completes immediately
//     dut_c : 4 channels, round-robin, memory that completes immediately
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n;
  int dones;

  // ---------------- instance A ----------------
  logic [1:0]  a_read, a_write, a_bw;
  logic [11:0] a_addr;
  logic [63:0] a_wdata;
  logic [31:0] a_rdata, a_mwd, a_mrd;
  logic        a_mr, a_mw, a_mbw;
  logic [5:0]  a_ma;
  logic [31:0] mem_a [64];
  int          cnt_a;
  int          lat_a = 5;

  mem_arbiter #(.NUM_CH(2), .ADDR_W(6), .DATA_W(32), .PRIO_MODE(0)) dut_a (
    .CLK(clk), .RESET(rst), .ch_read(a_read), .ch_write(a_write),
    .ch_address(a_addr), .ch_writedata(a_wdata), .ch_readdata(a_rdata),
    .ch_busywait(a_bw), .mem_read(a_mr), .mem_write(a_mw), .mem_address(a_ma),
    .mem_writedata(a_mwd), .mem_readdata(a_mrd), .mem_busywait(a_mbw)
  );

  // Memory A: busy for lat_a cycles after the strobe appears, writes on completion.
  assign a_mbw = (a_mr | a_mw) && (cnt_a < lat_a);
  assign a_mrd = mem_a[a_ma];
  always @(posedge clk) begin
    if (rst) begin
      cnt_a    <= 0;
      mem_a[1] <= 32'h0BAD_F00D;
      mem_a[5] <= 32'hDEAD_BEEF;
    end else if (a_mr | a_mw) begin
      if (cnt_a >= lat_a) begin
        if (a_mw) mem_a[a_ma] <= a_mwd;
        cnt_a <= 0;
      end else begin
        cnt_a <= cnt_a + 1;
      end
    end else begin
      cnt_a <= 0;
    end
  end

  // ---------------- instance B ----------------
  logic [1:0]  b_read, b_write, b_bw;
  logic [11:0] b_addr;
  logic [63:0] b_wdata;
  logic [31:0] b_rdata, b_mwd;
  logic        b_mr, b_mw;
  logic [5:0]  b_ma;

  mem_arbiter #(.NUM_CH(2), .ADDR_W(6), .DATA_W(32), .PRIO_MODE(1)) dut_b (
    .CLK(clk), .RESET(rst), .ch_read(b_read), .ch_write(b_write),
    .ch_address(b_addr), .ch_writedata(b_wdata), .ch_readdata(b_rdata),
    .ch_busywait(b_bw), .mem_read(b_mr), .mem_write(b_mw), .mem_address(b_ma),
    .mem_writedata(b_mwd), .mem_readdata(32'h0000_0000), .mem_busywait(1'b0)
  );

  // ---------------- instance C ----------------
  logic [3:0]   c_read, c_write, c_bw;
  logic [23:0]  c_addr;
  logic [127:0] c_wdata;
  logic [31:0]  c_rdata, c_mwd;
  logic         c_mr, c_mw;
  logic [5:0]   c_ma;

  mem_arbiter #(.NUM_CH(4), .ADDR_W(6), .DATA_W(32), .PRIO_MODE(0)) dut_c (
    .CLK(clk), .RESET(rst), .ch_read(c_read), .ch_write(c_write),
    .ch_address(c_addr), .ch_writedata(c_wdata), .ch_readdata(c_rdata),
    .ch_busywait(c_bw), .mem_read(c_mr), .mem_write(c_mw), .mem_address(c_ma),
    .mem_writedata(c_mwd), .mem_readdata(32'h0000_0000), .mem_busywait(1'b0)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and land on the falling edge, where outputs are sampled and inputs driven.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    a_read = 2'b00; a_write = 2'b00; a_addr = 12'h000; a_wdata = 64'h0;
    b_read = 2'b00; b_write = 2'b00; b_addr = {6'h22, 6'h11}; b_wdata = 64'h0;
    c_read = 4'b0000; c_write = 4'b0000;
    c_addr = {6'h33, 6'h32, 6'h31, 6'h30}; c_wdata = 128'h0;
    rst = 1'b1;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_mem_read", 64'(a_mr), 64'd0);
    check_eq("rst_mem_addr", 64'(a_ma), 64'd0);
    check_eq("rst_rdata", 64'(a_rdata), 64'd0);
    check_eq("rst_state", 64'(dut_a.state_q), 64'(IDLE));

    // ---- Single read, 5-cycle memory ----
    lat_a  = 5;
    a_addr = {6'h00, 6'h05};
    a_read = 2'b01;
    #1;
    check_eq("rd_stall_same_cycle", 64'(a_bw), 64'(2'b01));
    tick();
    check_eq("rd_strobe", 64'(a_mr), 64'd1);
    check_eq("rd_addr", 64'(a_ma), 64'h05);
    n = 0;
    while (a_bw[0] && n < 20) begin tick(); n++; end
    check_eq("rd_latency", 64'(n), 64'd6);
    check_eq("rd_data", 64'(a_rdata), 64'hDEADBEEF);
    check_eq("rd_strobe_dropped", 64'(a_mr), 64'd0);
    tick();  // request still held: treated as a new access, stalled again
    check_eq("rd_release_one_cycle", 64'(a_bw), 64'(2'b01));
    a_read = 2'b00;
    tick();
    check_eq("rd_back_idle", 64'(dut_a.state_q), 64'(IDLE));

    // ---- RR contention from reset ----
    rst = 1'b1; tick(); rst = 1'b0;
    lat_a   = 2;
    a_addr  = {6'h02, 6'h01};
    a_wdata = {32'h1234_5678, 32'h0000_0000};
    a_read  = 2'b01;
    a_write = 2'b10;
    tick();
    check_eq("rr1_ch0_read", 64'(a_mr), 64'd1);
    check_eq("rr1_ch0_addr", 64'(a_ma), 64'h01);
    n = 0;
    while (a_bw[0] && n < 20) begin tick(); n++; end
    check_eq("rr1_ch0_done_bw", 64'(a_bw), 64'(2'b10));
    check_eq("rr1_ch0_data", 64'(a_rdata), 64'h0BADF00D);
    tick();  // ch0 keeps requesting: the pair is presented again in IDLE
    check_eq("rr2_both_stalled", 64'(a_bw), 64'(2'b11));
    tick();
    check_eq("rr2_ch1_write", 64'(a_mw), 64'd1);
    check_eq("rr2_ch1_addr", 64'(a_ma), 64'h02);
    check_eq("rr2_ch1_wdata", 64'(a_mwd), 64'h12345678);
    n = 0;
    while (a_bw[1] && n < 20) begin tick(); n++; end
    check_eq("rr2_ch1_done_bw", 64'(a_bw), 64'(2'b01));
    check_eq("rr2_rdata_kept", 64'(a_rdata), 64'h0BADF00D);
    check_eq("rr2_mem_loc2", 64'(mem_a[2]), 64'h12345678);
    a_write = 2'b00;
    tick();
    tick();
    check_eq("rr3_ch0_again", 64'(a_ma), 64'h01);
    n = 0;
    while (a_bw[0] && n < 20) begin tick(); n++; end
    check_eq("rr3_ch0_latency", 64'(n), 64'd3);
    a_read = 2'b00;
    tick();

    // ---- RESET in the second BUSY cycle ----
    lat_a  = 5;
    a_addr = {6'h00, 6'h05};
    a_read = 2'b01;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_read = 2'b00;
    check_eq("rstb_mem_read", 64'(a_mr), 64'd0);
    check_eq("rstb_mem_write", 64'(a_mw), 64'd0);
    check_eq("rstb_state", 64'(dut_a.state_q), 64'(IDLE));
    check_eq("rstb_rdata", 64'(a_rdata), 64'd0);
    check_eq("rstb_rr_ptr", 64'(dut_a.rr_ptr_q), 64'd0);

    // ---- Fixed priority, both channels requesting continuously ----
    b_read = 2'b11;
    dones  = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (dut_b.state_q == DONE) begin
        dones++;
        check_eq("fix_done_ch0", 64'(b_bw), 64'(2'b10));
      end
      if (b_mr) check_eq("fix_addr_ch0", 64'(b_ma), 64'h11);
    end
    check_eq("fix_done_count", 64'(dones), 64'd4);
    n = 0;
    while (dut_b.state_q != DONE && n < 10) begin tick(); n++; end
    b_read = 2'b10;
    n = 0;
    while (!(b_mr && b_ma == 6'h22) && n < 10) begin tick(); n++; end
    check_eq("fix_ch1_after_release", 64'(n), 64'd2);
    b_read = 2'b00;

    // ---- NUM_CH=4 wrap ----
    c_read = 4'b0100;
    tick();
    check_eq("wrap_ch2_addr", 64'(c_ma), 64'h32);
    n = 0;
    while (c_bw[2] && n < 20) begin tick(); n++; end
    c_read = 4'b0000;
    tick();
    check_eq("wrap_rr_at3", 64'(dut_c.rr_ptr_q), 64'd3);
    c_read = 4'b1010;
    tick();
    check_eq("wrap_ch3_first", 64'(c_ma), 64'h33);
    n = 0;
    while (c_bw[3] && n < 20) begin tick(); n++; end
    check_eq("wrap_ch3_done_bw", 64'(c_bw), 64'(4'b0010));
    c_read = 4'b0010;
    tick();
    tick();
    check_eq("wrap_ch1_second", 64'(c_ma), 64'h31);
    n = 0;
    while (c_bw[1] && n < 20) begin tick(); n++; end
    c_read = 4'b0000;
    tick();
    check_eq("wrap_rr_end", 64'(dut_c.rr_ptr_q), 64'd2);

    // ---- ch0 drops its read mid-BUSY ----
    lat_a  = 3;
    a_addr = {6'h00, 6'h05};
    a_read = 2'b01;
    tick();
    tick();
    a_read = 2'b00;
    #1;
    check_eq("drop_bw_masked", 64'(a_bw), 64'(2'b00));
    n = 0;
    while (a_mr && n < 20) begin tick(); n++; end
    check_eq("drop_access_finishes", 64'(n), 64'd3);
    check_eq("drop_state_done", 64'(dut_a.state_q), 64'(DONE));
    check_eq("drop_done_bw", 64'(a_bw), 64'(2'b00));
    check_eq("drop_rdata", 64'(a_rdata), 64'hDEADBEEF);
    tick();
    check_eq("drop_idle", 64'(dut_a.state_q), 64'(IDLE));
    check_eq("drop_rr_ptr", 64'(dut_a.rr_ptr_q), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
